// File: rtl/uart_frame_parser.sv
// Parses SYNC/LEN/payload/CHK frames from a UART byte stream, emitting payload
// strobes and per-frame done/error pulses, with an inter-byte timeout.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 4200
) (
  input  logic       ip_Clock,
  input  logic       ip_Reset,
  input  logic       ip_Rx_DV,
  input  logic [7:0] ip_Rx_Byte,
  output logic       op_Data_Valid,
  output logic [7:0] op_Data_Byte,
  output logic [3:0] op_Data_Index,
  output logic [4:0] op_Frame_Len,
  output logic       op_Frame_Done,
  output logic       op_Frame_Err,
  output logic [1:0] op_Err_Code,
  output logic       op_Busy
);

  localparam int unsigned CNT_W = 13;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHECK
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         acc_q, acc_d;
  logic               data_valid_q, data_valid_d;
  logic [7:0]         data_byte_q, data_byte_d;
  logic [3:0]         data_index_q, data_index_d;
  logic [4:0]         frame_len_q, frame_len_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               busy_q, busy_d;

  logic timeout_hit;
  logic len_ok;
  logic last_byte;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CLKS - 1));
  assign len_ok      = (ip_Rx_Byte != 8'd0) && (ip_Rx_Byte <= 8'(MAX_LEN));
  assign last_byte   = ({1'b0, idx_q} == (frame_len_q - 5'd1));

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    data_valid_d = 1'b0;
    data_byte_d  = data_byte_q;
    data_index_d = data_index_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;

    // Inter-byte timer: cleared by every byte, saturates rather than wrapping
    if (ip_Rx_DV) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (ip_Rx_DV && (ip_Rx_Byte == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (ip_Rx_DV) begin
          if (len_ok) begin
            frame_len_d = 5'(ip_Rx_Byte);
            acc_d       = ip_Rx_Byte;
            idx_d       = 4'd0;
            state_d     = S_PAYLOAD;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_IDLE;
          end
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (ip_Rx_DV) begin
          data_valid_d = 1'b1;
          data_byte_d  = ip_Rx_Byte;
          data_index_d = idx_q;
          acc_d        = acc_q ^ ip_Rx_Byte;
          idx_d        = idx_q + 4'd1;
          if (last_byte) begin
            state_d = S_CHECK;
          end
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_IDLE;
        end
      end
      S_CHECK: begin
        if (ip_Rx_DV) begin
          if (ip_Rx_Byte == acc_q) begin
            frame_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset overrides any byte in the same cycle
  always_ff @(posedge ip_Clock) begin
    if (ip_Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      data_valid_q <= 1'b0;
      data_byte_q  <= '0;
      data_index_q <= '0;
      frame_len_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      data_valid_q <= data_valid_d;
      data_byte_q  <= data_byte_d;
      data_index_q <= data_index_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
    end
  end

  assign op_Data_Valid = data_valid_q;
  assign op_Data_Byte  = data_byte_q;
  assign op_Data_Index = data_index_q;
  assign op_Frame_Len  = frame_len_q;
  assign op_Frame_Done = frame_done_q;
  assign op_Frame_Err  = frame_err_q;
  assign op_Err_Code   = err_code_q;
  assign op_Busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser with hand-computed frames.
module tb_uart_frame_parser;

  localparam int unsigned TIMEOUT = 4200;

  logic       clk;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       data_valid;
  logic [7:0] data_byte;
  logic [3:0] data_index;
  logic [4:0] frame_len;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int n_data = 0;
  int n_done = 0;
  int n_err = 0;
  logic both_seen = 1'b0;

  uart_frame_parser #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (16),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .ip_Clock     (clk),
    .ip_Reset     (rst),
    .ip_Rx_DV     (rx_dv),
    .ip_Rx_Byte   (rx_byte),
    .op_Data_Valid(data_valid),
    .op_Data_Byte (data_byte),
    .op_Data_Index(data_index),
    .op_Frame_Len (frame_len),
    .op_Frame_Done(frame_done),
    .op_Frame_Err (frame_err),
    .op_Err_Code  (err_code),
    .op_Busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle so each one-cycle strobe counts once
  always @(negedge clk) begin
    if (data_valid) n_data <= n_data + 1;
    if (frame_done) n_done <= n_done + 1;
    if (frame_err)  n_err  <= n_err + 1;
    if (frame_done && frame_err) both_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one cycle; outputs are sampled just after the edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_data(input string tag, input logic [7:0] b, input logic [3:0] idx);
    send_byte(b);
    check({tag, "_valid"}, 32'(data_valid), 32'd1);
    check({tag, "_byte"}, 32'(data_byte), 32'(b));
    check({tag, "_idx"}, 32'(data_index), 32'(idx));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_err"}, 32'(frame_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_byte"}, 32'(data_byte), 32'd0);
    check({tag, "_idx"}, 32'(data_index), 32'd0);
    check({tag, "_len"}, 32'(frame_len), 32'd0);
    check({tag, "_code"}, 32'(err_code), 32'd0);
  endtask

  int base_data, base_err, base_done;
  int err_at;

  initial begin
    rst = 1'b1;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    // Good frame A5 03 11 22 33 03
    base_data = n_data; base_err = n_err;
    send_byte(8'hA5);
    check("good_busy", 32'(busy), 32'd1);
    send_byte(8'h03);
    check("good_len", 32'(frame_len), 32'd3);
    send_data("good_d0", 8'h11, 4'd0);
    send_data("good_d1", 8'h22, 4'd1);
    send_data("good_d2", 8'h33, 4'd2);
    send_byte(8'h03);
    check("good_done", 32'(frame_done), 32'd1);
    check("good_noerr", 32'(frame_err), 32'd0);
    check("good_nodv", 32'(data_valid), 32'd0);
    idle(1);
    check("good_done_1clk", 32'(frame_done), 32'd0);
    check("good_hold_byte", 32'(data_byte), 32'h33);
    check("good_hold_idx", 32'(data_index), 32'd2);
    check("good_idle", 32'(busy), 32'd0);
    check("good_strobes", 32'(n_data - base_data), 32'd3);
    check("good_no_errs", 32'(n_err - base_err), 32'd0);

    // Bad checksum A5 03 11 22 33 04
    base_data = n_data; base_done = n_done;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h04);
    check("chk_err", 32'(frame_err), 32'd1);
    check("chk_code", 32'(err_code), 32'd2);
    check("chk_nodone", 32'(frame_done), 32'd0);
    idle(2);
    check("chk_code_hold", 32'(err_code), 32'd2);
    check("chk_strobes", 32'(n_data - base_data), 32'd3);
    check("chk_dones", 32'(n_done - base_done), 32'd0);

    // Bad lengths: zero, then MAX_LEN+1
    base_data = n_data;
    send_byte(8'hA5);
    send_byte(8'h00);
    check("len0_err", 32'(frame_err), 32'd1);
    check("len0_code", 32'(err_code), 32'd1);
    idle(1);
    send_byte(8'hA5);
    send_byte(8'h11);
    check("len17_err", 32'(frame_err), 32'd1);
    check("len17_code", 32'(err_code), 32'd1);
    idle(1);
    check("len_strobes", 32'(n_data - base_data), 32'd0);
    check("len_idle", 32'(busy), 32'd0);

    // Minimum length frame directly after: A5 01 7E 7F
    send_byte(8'hA5);
    send_byte(8'h01);
    send_data("min_d0", 8'h7E, 4'd0);
    send_byte(8'h7F);
    check("min_done", 32'(frame_done), 32'd1);
    // Back-to-back frame with SYNC value inside payload: A5 02 A5 5A FD
    send_byte(8'hA5);
    send_byte(8'h02);
    check("b2b_len", 32'(frame_len), 32'd2);
    send_data("b2b_d0", 8'hA5, 4'd0);
    send_data("b2b_d1", 8'h5A, 4'd1);
    send_byte(8'hFD);
    check("b2b_done", 32'(frame_done), 32'd1);
    idle(1);

    // Timeout: A5 02 11 then silence
    send_byte(8'hA5);
    send_byte(8'h02);
    send_data("to_d0", 8'h11, 4'd0);
    @(negedge clk);
    rx_dv = 1'b0;
    err_at = -1;
    for (int k = 1; k <= int'(TIMEOUT) + 10; k++) begin
      @(posedge clk);
      #1;
      if (frame_err && err_at < 0) begin
        err_at = k;
        check("to_code", 32'(err_code), 32'd3);
        check("to_busy_drop", 32'(busy), 32'd0);
      end
    end
    check("to_latency", 32'(err_at), 32'(TIMEOUT));

    // Byte arriving on the expiry cycle wins: A5 02 11 (wait) 22 31
    base_err = n_err;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_data("race_d0", 8'h11, 4'd0);
    idle(int'(TIMEOUT) - 1);
    send_data("race_d1", 8'h22, 4'd1);
    check("race_noerr", 32'(frame_err), 32'd0);
    send_byte(8'h31);
    check("race_done", 32'(frame_done), 32'd1);
    idle(1);
    check("race_errs", 32'(n_err - base_err), 32'd0);

    // Garbage before a frame produces nothing
    base_data = n_data; base_err = n_err; base_done = n_done;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    idle(1);
    check("garb_busy", 32'(busy), 32'd0);
    check("garb_out", 32'(n_data - base_data + n_err - base_err + n_done - base_done), 32'd0);

    // Reset mid-frame with a SYNC byte presented during reset
    send_byte(8'hA5);
    send_byte(8'h04);
    send_data("mid_d0", 8'hAA, 4'd0);
    base_err = n_err;
    @(negedge clk);
    rst = 1'b1;
    rx_dv = 1'b1;
    rx_byte = 8'hA5;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    rx_dv = 1'b0;
    base_data = n_data;
    send_byte(8'hBB);
    send_byte(8'hCC);
    idle(1);
    check("trail_busy", 32'(busy), 32'd0);
    check("trail_strobes", 32'(n_data - base_data), 32'd0);
    check("midrst_noerr", 32'(n_err - base_err), 32'd0);
    // Good frame after reset: A5 02 C3 3C FD
    send_byte(8'hA5);
    send_byte(8'h02);
    send_data("post_d0", 8'hC3, 4'd0);
    send_data("post_d1", 8'h3C, 4'd1);
    send_byte(8'hFD);
    check("post_done", 32'(frame_done), 32'd1);
    idle(2);
    check("never_both", 32'(both_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL provide parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL provide parameter MAX_LEN, default 16, the largest legal payload length in bytes (1..16).
REQ-003 SHALL provide parameter TIMEOUT_CLKS, default 4200, the inter-byte timeout in clocks (about 4 byte times at 105 clks/bit).
REQ-004 SHALL have ports:
- ip_Clock  input  1  sole clock; all logic on posedge.
- ip_Reset  input  1  synchronous, active-high reset.
- ip_Rx_DV  input  1  one-cycle strobe from the UART receiver; a byte is present.
- ip_Rx_Byte  input  8  received byte; valid when ip_Rx_DV=1.
- op_Data_Valid  output  1  one-cycle strobe; a payload byte is present.
- op_Data_Byte  output  8  payload byte.
- op_Data_Index  output  4  position of the payload byte in the frame, 0-based.
- op_Frame_Len  output  5  LEN of the current or last frame.
- op_Frame_Done  output  1  one-cycle pulse; the frame completed and its checksum matched.
- op_Frame_Err  output  1  one-cycle pulse; the frame was aborted.
- op_Err_Code  output  2  01 bad length, 10 checksum mismatch, 11 timeout; holds until the next error.
- op_Busy  output  1  high in any state other than IDLE.
REQ-005 SHALL use one clock domain; reset is synchronous and active-high.

Function
REQ-006 Frame format SHALL be: SYNC, LEN, LEN payload bytes, CHK.
- CHK = XOR of LEN and all payload bytes.
REQ-007 SHALL implement FSM states IDLE, LEN, PAYLOAD, CHECK; encoding is free.
REQ-008 IDLE SHALL behave as follows:
- ip_Rx_DV with byte == SYNC_BYTE -> LEN.
- Any other byte -> ignored, no output.
REQ-009 LEN SHALL behave as follows on ip_Rx_DV:
- Byte in 1..MAX_LEN -> latch op_Frame_Len, set checksum accumulator = byte, clear index, go to PAYLOAD.
- Byte of 0 or >MAX_LEN -> op_Frame_Err pulse, op_Err_Code=01, go to IDLE.
REQ-010 PAYLOAD SHALL behave as follows on each ip_Rx_DV:
- Output the byte with op_Data_Valid=1 and op_Data_Index = current index.
- XOR the byte into the accumulator and increment the index.
- After the LEN-th byte, go to CHECK.
REQ-011 CHECK SHALL behave as follows on ip_Rx_DV:
- Byte == accumulator -> op_Frame_Done pulse.
- Otherwise -> op_Frame_Err pulse, op_Err_Code=10.
- Either case -> IDLE.
REQ-012 All outputs SHALL be registered; latency from the ip_Rx_DV cycle to the output strobe is exactly 1 clock.
REQ-013 Timeout: a counter SHALL run in every non-IDLE state.
- Cleared on each ip_Rx_DV.
- Reaching TIMEOUT_CLKS-1 -> op_Frame_Err pulse, op_Err_Code=11, go to IDLE.
- ip_Rx_DV in the same cycle as expiry -> the byte wins and the counter clears.
REQ-014 A SYNC_BYTE value received inside LEN, PAYLOAD or CHECK SHALL be treated as ordinary data; it does not resynchronise.
REQ-015 op_Frame_Done and op_Frame_Err SHALL never be high in the same cycle, and each SHALL be high for exactly one clock per frame.
REQ-016 op_Data_Byte and op_Data_Index SHALL hold their last values when op_Data_Valid=0.
REQ-017 Back-to-back frames SHALL be accepted: a SYNC arriving on the first ip_Rx_DV after CHECK starts a new frame.
REQ-018 The timeout counter SHALL be 13 bits wide.
- It SHALL saturate and not wrap.

Reset
REQ-019 While ip_Reset=1 at posedge, the block SHALL apply the following:
- FSM -> IDLE.
- Counter, index and accumulator -> 0.
- op_Data_Valid, op_Frame_Done, op_Frame_Err, op_Busy -> 0.
- op_Data_Byte -> 0, op_Data_Index -> 0, op_Frame_Len -> 0, op_Err_Code -> 00.
REQ-020 Reset asserted mid-frame SHALL abandon the frame with no op_Frame_Err pulse.
- Bytes after reset release are parsed from IDLE.
REQ-021 ip_Rx_DV SHALL be ignored in any cycle where ip_Reset=1.

Verification
REQ-022 Good frame: A5 03 11 22 33 03.
- op_Data_Valid three times: 11/idx0, 22/idx1, 33/idx2.
- op_Frame_Len=3.
- op_Frame_Done pulses 1 clk after the last byte.
REQ-023 Bad checksum: A5 03 11 22 33 04.
- Three data strobes.
- op_Frame_Err pulse, op_Err_Code=10, no op_Frame_Done.
REQ-024 Bad length: A5 00, then separately A5 11.
- Each gives op_Frame_Err with op_Err_Code=01 and no data strobes.
- A following good frame is parsed correctly.
REQ-025 Timeout: A5 02 11 then no bytes.
- op_Frame_Err and op_Err_Code=11 exactly TIMEOUT_CLKS clocks after the 11 strobe.
- op_Busy then drops.
REQ-026 Garbage and reset: 00 FF 5A before a good frame produces no output.
- ip_Reset pulse after A5 04 AA -> all outputs at reset values.
- Trailing bytes are ignored until the next A5.
